calc_controller: RTL and testbench
==================================

// Module: calc_controller
// PURPOSE
//  Sequencer directly upstream of the 32-bit adder: streams operand pairs from operand SRAM,
//  drives the adder's a/b inputs from registers, captures the combinational sum and writes it
//  to result SRAM. One pair per 4 clocks; start/busy/done control toward the calculator top.
// PARAMETERS
//  DATA_W  32  operand/result width (calculator_pkg::DATA_W; not overridden locally)
//  ADDR_W  10  SRAM address width (calculator_pkg::ADDR_W)
// PORTS
//  clk_i         in   1         clock, all state on rising edge
//  rst_ni        in   1         asynchronous, active-low reset
//  start_i       in   1         begin run; sampled only in IDLE
//  rd_start_i    in   ADDR_W    first operand-pair address
//  rd_end_i      in   ADDR_W    last operand-pair address (inclusive)
//  wr_start_i    in   ADDR_W    first result address
//  rd_en_o       out  1         SRAM read strobe
//  rd_addr_o     out  ADDR_W    SRAM read address
//  rd_data_i     in   2*DATA_W  read data, valid cycle after rd_en_o; [2W-1:W]=a, [W-1:0]=b
//  op_a_o        out  DATA_W    to adder a_i (registered)
//  op_b_o        out  DATA_W    to adder b_i (registered)
//  sum_i         in   DATA_W    from adder sum_o (combinational)
//  wr_en_o       out  1         result SRAM write strobe
//  wr_addr_o     out  ADDR_W    result address
//  wr_data_o     out  DATA_W    result data (registered)
//  busy_o        out  1         high in every state except IDLE
//  done_o        out  1         one-cycle pulse at end of run
// BEHAVIOUR
//  - Reset (async, rst_ni=0): state=IDLE; all outputs, op/result regs, addr counters = 0.
//  - FSM: IDLE -start_i-> READ -> WAIT -> ADD -> WRITE -> (rd_addr==end_addr ? DONE : READ);
//    DONE -> IDLE unconditionally.
//  - IDLE+start_i: latch rd_start_i->rd_addr, rd_end_i->end_addr, wr_start_i->wr_addr.
//    If rd_end_i < rd_start_i: go IDLE->DONE, zero reads/writes, done_o still pulses.
//  - READ: rd_en_o=1, rd_addr_o=rd_addr. WAIT: capture rd_data_i into op_a/op_b regs.
//  - ADD: op regs stable on adder; capture sum_i into result reg. WRITE: wr_en_o=1,
//    wr_addr_o=wr_addr, wr_data_o=result; then rd_addr++, wr_addr++.
//  - rd_en_o/wr_en_o high only in READ/WRITE. done_o high only in DONE (exactly 1 cycle).
//  - Latency: start_i at edge N -> first wr_en_o in cycle N+4; a run of K pairs lasts 4K+1 cycles
//    incl. DONE; busy_o drops the cycle after done_o.
//  - Arithmetic: sum is modulo 2^DATA_W (adder has no carry out); no saturation.
//  - wr_addr increments modulo 2^ADDR_W (wraps 2^ADDR_W-1 -> 0). rd_addr stops at end_addr.
//  - start_i while busy_o=1: ignored; latched inputs not re-sampled mid-run.
//  - Input address ports may change during a run without effect.
//  - Reset mid-run: immediate IDLE, pending write abandoned, no done_o.
// CONFIGURATION
//  CALC_CTRL_OVF_EN defined: extra port ovf_o (out, 1): sticky signed-overflow flag;
//    set in ADD when sign(a)==sign(b) && sign(sum)!=sign(a); cleared on reset and on accepted start_i.
//  Undefined: no ovf_o port, no overflow logic; all other behaviour identical.
// STRUCTURE
//  - calculator_pkg: DATA_W, ADDR_W, typedef enum logic [2:0] {IDLE,READ,WAIT,ADD,WRITE,DONE}
//    calc_state_t.
//  - Single module, no sub-modules; adder32 instantiated beside it at calculator top.
// TESTING (bench instantiates calc_controller + adder32 + 1-cycle-latency SRAM model)
//  - Reset: rst_ni=0 -> all outputs 0, busy_o=0; release -> stays IDLE without start_i.
//  - Single pair: mem[5]={32'd7,32'd9}, rd 5..5, wr 20 -> mem[20]=16 in cycle N+4, done_o at N+5.
//  - Run 0..3 with a=i, b=100*i -> results 0,101,202,303 at wr 8..11; 17 cycles busy; start_i
//    pulse during run ignored.
//  - Wrap: {FFFF_FFFF,1}->0; wr_start=1023 with 2 pairs -> writes at 1023 then 0.
//  - Empty range rd 4..2 -> no rd_en_o/wr_en_o, done_o pulses once.
//  - Reset mid-run (in ADD) -> IDLE next edge, no write, no done_o; OVF_EN: {7FFF_FFFF,1}
//    -> ovf_o=1 sticky until next start.

Source files
------------

// File: rtl/calculator_pkg.sv
`default_nettype none
// ============================================================================
// Module  : calculator_pkg
// Purpose : Shared widths and the sequencer state type for the calculator
//           datapath (operand SRAM -> adder -> result SRAM).
// Contents: DATA_W   operand/result width
//           ADDR_W   SRAM address width
//           calc_state_t  IDLE/READ/WAIT/ADD/WRITE/DONE sequencer states
// Revision: 1.0  initial release
// ============================================================================
package calculator_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    ADD   = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } calc_state_t;

endpackage
`default_nettype wire

// File: rtl/calc_controller.sv
`default_nettype none
// ============================================================================
// Module  : calc_controller
// Purpose : Sequencer in front of the 32-bit adder. Streams operand pairs
//           from operand SRAM, presents them to the adder from registers,
//           captures the combinational sum and writes it to result SRAM.
//           One pair every 4 clocks (READ, WAIT, ADD, WRITE).
// Ports   : clk_i, rst_ni        clock / async active-low reset
//           start_i              begin a run (sampled only when idle)
//           rd_start_i/rd_end_i  inclusive operand-pair address range
//           wr_start_i           first result address
//           rd_en_o/rd_addr_o    operand SRAM read port (data next cycle
//                                on rd_data_i, {a, b})
//           op_a_o/op_b_o        registered adder operands
//           sum_i                combinational adder sum
//           wr_en_o/wr_addr_o/wr_data_o  result SRAM write port
//           busy_o               high whenever not idle
//           done_o               one-cycle pulse at the end of a run
//           ovf_o                sticky signed-overflow flag (optional)
// Config  : define CALC_CTRL_OVF_EN to add ovf_o and the overflow tracking.
// Revision: 1.0  initial release
// ============================================================================
module calc_controller
  import calculator_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [ADDR_W-1:0]   rd_start_i,
  input  logic [ADDR_W-1:0]   rd_end_i,
  input  logic [ADDR_W-1:0]   wr_start_i,
  output logic                rd_en_o,
  output logic [ADDR_W-1:0]   rd_addr_o,
  input  logic [2*DATA_W-1:0] rd_data_i,
  output logic [DATA_W-1:0]   op_a_o,
  output logic [DATA_W-1:0]   op_b_o,
  input  logic [DATA_W-1:0]   sum_i,
  output logic                wr_en_o,
  output logic [ADDR_W-1:0]   wr_addr_o,
  output logic [DATA_W-1:0]   wr_data_o,
  output logic                busy_o,
`ifdef CALC_CTRL_OVF_EN
  output logic                ovf_o,
`endif
  output logic                done_o
);

  localparam logic [ADDR_W-1:0] c_addr_one = ADDR_W'(1);

  calc_state_t         r_state;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic [ADDR_W-1:0]   r_end_addr;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_op_a;
  logic [DATA_W-1:0]   r_op_b;
  logic [DATA_W-1:0]   r_result;
  logic                r_rd_en;
  logic                r_wr_en;
  logic                r_busy;
  logic                r_done;

`ifdef CALC_CTRL_OVF_EN
  logic                r_ovf;
  logic                w_ovf;

  // Two operands of equal sign producing a sum of the opposite sign is a
  // two's-complement overflow.
  assign w_ovf = (r_op_a[DATA_W-1] == r_op_b[DATA_W-1]) &&
                 (sum_i[DATA_W-1]  != r_op_a[DATA_W-1]);
  assign ovf_o = r_ovf;
`endif

  // All strobes and flags are registered; they are set on entry to the
  // state that owns them and cleared on exit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_rd_addr  <= '0;
      r_end_addr <= '0;
      r_wr_addr  <= '0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_result   <= '0;
      r_rd_en    <= 1'b0;
      r_wr_en    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef CALC_CTRL_OVF_EN
      r_ovf      <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_rd_addr  <= rd_start_i;
            r_end_addr <= rd_end_i;
            r_wr_addr  <= wr_start_i;
            r_busy     <= 1'b1;
`ifdef CALC_CTRL_OVF_EN
            r_ovf      <= 1'b0;
`endif
            // An inverted range is an empty run: no transfers, but the
            // requester still gets its done pulse.
            if (rd_end_i < rd_start_i) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= READ;
              r_rd_en <= 1'b1;
            end
          end
        end

        READ: begin
          r_rd_en <= 1'b0;
          r_state <= WAIT;
        end

        WAIT: begin
          r_op_a  <= rd_data_i[2*DATA_W-1:DATA_W];
          r_op_b  <= rd_data_i[DATA_W-1:0];
          r_state <= ADD;
        end

        ADD: begin
          r_result <= sum_i;
          r_wr_en  <= 1'b1;
          r_state  <= WRITE;
`ifdef CALC_CTRL_OVF_EN
          if (w_ovf) begin
            r_ovf <= 1'b1;
          end
`endif
        end

        WRITE: begin
          r_wr_en   <= 1'b0;
          // Result address wraps naturally at the counter width.
          r_wr_addr <= r_wr_addr + c_addr_one;
          if (r_rd_addr == r_end_addr) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_rd_addr <= r_rd_addr + c_addr_one;
            r_rd_en   <= 1'b1;
            r_state   <= READ;
          end
        end

        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_rd_en <= 1'b0;
          r_wr_en <= 1'b0;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign rd_en_o   = r_rd_en;
  assign rd_addr_o = r_rd_addr;
  assign op_a_o    = r_op_a;
  assign op_b_o    = r_op_b;
  assign wr_en_o   = r_wr_en;
  assign wr_addr_o = r_wr_addr;
  assign wr_data_o = r_result;
  assign busy_o    = r_busy;
  assign done_o    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_calc_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_calc_controller
// Purpose : Self-checking bench for calc_controller with an inline adder and
//           a 1-cycle-latency operand SRAM. Expected writes are queued when a
//           run is issued; a negedge monitor pops and compares every write.
// Config  : CALC_CTRL_OVF_EN enables the overflow-flag checks.
// Revision: 1.0  initial release
// ============================================================================
module tb_calc_controller;
  import calculator_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic [ADDR_W-1:0]   rd_start, rd_end, wr_start;
  logic                rd_en;
  logic [ADDR_W-1:0]   rd_addr;
  logic [2*DATA_W-1:0] rd_data = '0;
  logic [DATA_W-1:0]   op_a, op_b, sum, wr_data;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic                busy, done;
`ifdef CALC_CTRL_OVF_EN
  logic                ovf;
`endif

  always #5 clk = ~clk;

  calc_controller dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .rd_start_i (rd_start),
    .rd_end_i   (rd_end),
    .wr_start_i (wr_start),
    .rd_en_o    (rd_en),
    .rd_addr_o  (rd_addr),
    .rd_data_i  (rd_data),
    .op_a_o     (op_a),
    .op_b_o     (op_b),
    .sum_i      (sum),
    .wr_en_o    (wr_en),
    .wr_addr_o  (wr_addr),
    .wr_data_o  (wr_data),
    .busy_o     (busy),
`ifdef CALC_CTRL_OVF_EN
    .ovf_o      (ovf),
`endif
    .done_o     (done)
  );

  // Adder stand-in and operand SRAM (data one cycle after the read strobe).
  assign sum = op_a + op_b;
  logic [2*DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  vectors = 0;
  int  miscompares = 0;
  int  cyc = 0;
  int  rd_cnt = 0, wr_cnt = 0, done_cnt = 0, busy_cnt = 0;
  int  first_wr_cyc = -1, done_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: counts strobes and scores every result write.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (rd_en) rd_cnt++;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (wr_en) begin
        wr_cnt++;
        if (first_wr_cyc < 0) first_wr_cyc = cyc;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", wr_addr, wr_data);
        end else begin
          mon_e = exp_q.pop_front();
          if (wr_addr !== mon_e.addr || wr_data !== mon_e.data) begin
            miscompares++;
            $display("FAIL write: got addr=%0d data=%h, required addr=%0d data=%h",
                     wr_addr, wr_data, mon_e.addr, mon_e.data);
          end
        end
      end
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Issue one run, queue its expected writes from the address/sum rules,
  // then check timing and strobe counts once done has been seen.
  task automatic run_job(input int rs, input int re, input int ws, input bit poke, input string tag);
    int k, n, rd0, wr0, dn0, bz0, waited;
    longint a, b;
    k = (re < rs) ? 0 : re - rs + 1;
    for (int i = 0; i < k; i++) begin
      a = longint'(mem[rs + i][2*DATA_W-1:DATA_W]);
      b = longint'(mem[rs + i][DATA_W-1:0]);
      exp_q.push_back('{addr: ADDR_W'((ws + i) % (1 << ADDR_W)),
                        data: DATA_W'((a + b) % (longint'(1) << DATA_W))});
    end
    rd0 = rd_cnt; wr0 = wr_cnt; dn0 = done_cnt; bz0 = busy_cnt;
    first_wr_cyc = -1;
    @(negedge clk);
    rd_start = ADDR_W'(rs); rd_end = ADDR_W'(re); wr_start = ADDR_W'(ws);
    start = 1'b1;
    @(posedge clk); #1;
    n = cyc;
    start = 1'b0;
    // Address ports must be ignored once the run is under way.
    rd_start = ADDR_W'($urandom); rd_end = ADDR_W'($urandom); wr_start = ADDR_W'($urandom);
    waited = 0;
    while (done_cnt == dn0 && waited < 4*k + 20) begin
      @(negedge clk); #1;
      waited++;
      start = (poke && waited == 5);
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check({tag, " done_pulses"}, done_cnt - dn0, 1);
    check({tag, " done_cycle"}, done_cyc - n, 4*k);
    check({tag, " reads"}, rd_cnt - rd0, k);
    check({tag, " writes"}, wr_cnt - wr0, k);
    check({tag, " busy_cycles"}, busy_cnt - bz0, 4*k + 1);
    check({tag, " first_write_cycle"}, (k > 0) ? first_wr_cyc - n : first_wr_cyc, (k > 0) ? 3 : -1);
    check({tag, " pending_writes"}, exp_q.size(), 0);
    check({tag, " busy_after"}, busy, 0);
    exp_q.delete();
  endtask

  initial begin
    int n, rd0, wr0, dn0, rs, len;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = {$urandom, $urandom};
    rst_n = 1'b0; start = 1'b0; rd_start = '0; rd_end = '0; wr_start = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst rd_en", rd_en, 0);
    check("rst rd_addr", rd_addr, 0);
    check("rst op_a", op_a, 0);
    check("rst op_b", op_b, 0);
    check("rst wr_en", wr_en, 0);
    check("rst wr_addr", wr_addr, 0);
    check("rst wr_data", wr_data, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
`ifdef CALC_CTRL_OVF_EN
    check("rst ovf", ovf, 0);
`endif
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle busy", busy, 0);
    check("idle reads", rd_cnt, 0);

    // Single pair: 7 + 9 written to address 20.
    mem[5] = {32'd7, 32'd9};
    run_job(5, 5, 20, 1'b0, "single");

    // Four pairs a=i, b=100*i with a stray start pulse mid-run.
    for (int i = 0; i < 4; i++) mem[i] = {DATA_W'(i), DATA_W'(100 * i)};
    run_job(0, 3, 8, 1'b1, "run4");

    // Modulo sum and result-address wrap.
    mem[40] = {32'hFFFF_FFFF, 32'd1};
    run_job(40, 41, 1023, 1'b0, "wrap");

    // Empty range.
    run_job(4, 2, 0, 1'b0, "empty");

    // Reset while the first pair is in ADD.
    rd0 = rd_cnt; wr0 = wr_cnt; dn0 = done_cnt;
    @(negedge clk);
    rd_start = 10'd10; rd_end = 10'd13; wr_start = 10'd50; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst busy", busy, 0);
    check("midrst wr_en", wr_en, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    check("midrst writes", wr_cnt - wr0, 0);
    check("midrst done", done_cnt - dn0, 0);
    check("midrst reads", rd_cnt - rd0, 1);

`ifdef CALC_CTRL_OVF_EN
    mem[30] = {32'h7FFF_FFFF, 32'd1};
    mem[31] = {32'd1, 32'd1};
    run_job(30, 31, 100, 1'b0, "ovf_set");
    check("ovf sticky", ovf, 1);
    mem[32] = {32'd2, 32'd3};
    run_job(32, 32, 101, 1'b0, "ovf_clr");
    check("ovf cleared", ovf, 0);
`endif

    // Randomized runs, including result-address wrap.
    for (int t = 0; t < 8; t++) begin
      rs  = int'($urandom_range(0, 1000));
      len = int'($urandom_range(1, 6));
      run_job(rs, rs + len - 1, int'($urandom_range(1015, 1023)) - ((t % 2) * 500), 1'b0, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
